// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register with stall/flush
// handling, and saturating debug counters for stall and flush cycles.
module fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0040_0000,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 PC_write_i,
   input  logic                 IFID_write_i,
   input  logic                 redirect_i,
   input  logic [31:0]          redirect_pc_i,
   input  logic [31:0]          instr_i,
   output logic [31:0]          pc_o,
   output logic [31:0]          pc_plus4_IFID_o,
   output logic [31:0]          instr_IFID_o,
   output logic                 valid_IFID_o,
   output logic [CNT_WIDTH-1:0] stall_count_o,
   output logic [CNT_WIDTH-1:0] flush_count_o
);

   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

   logic [31:0]          r_pc;
   logic [31:0]          r_instr;
   logic [31:0]          r_pc_plus4;
   logic                 r_valid;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;

   logic                 w_redir_eff;
   logic [31:0]          w_pc_plus4;

   // A branch held in ID by a stall is re-evaluated next cycle, so only act when not stalled.
   assign w_redir_eff = redirect_i & PC_write_i & IFID_write_i;
   assign w_pc_plus4  = r_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc        <= PC_RESET;
         r_instr     <= 32'h0;
         r_pc_plus4  <= 32'h0;
         r_valid     <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_redir_eff) begin
            r_pc <= {redirect_pc_i[31:2], 2'b00};
         end else if (PC_write_i) begin
            r_pc <= w_pc_plus4;
         end

         if (w_redir_eff) begin
            r_instr    <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
         end else if (IFID_write_i) begin
            r_instr    <= instr_i;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
         end

         if (!IFID_write_i && (r_stall_cnt != CntMax)) begin
            r_stall_cnt <= r_stall_cnt + CntOne;
         end
         if (w_redir_eff && (r_flush_cnt != CntMax)) begin
            r_flush_cnt <= r_flush_cnt + CntOne;
         end
      end
   end

   assign pc_o            = r_pc;
   assign pc_plus4_IFID_o = r_pc_plus4;
   assign instr_IFID_o    = r_instr;
   assign valid_IFID_o    = r_valid;
   assign stall_count_o   = r_stall_cnt;
   assign flush_count_o   = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a cycle model,
// run on a 16-bit-counter instance and a 2-bit-counter instance sharing the same stimulus.
module tb_fetch_stage;

   localparam logic [31:0] PcReset = 32'h0040_0000;
   localparam logic [31:0] InstrKey = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_wr;
   logic        ifid_wr;
   logic        redir;
   logic [31:0] redir_pc;
   logic [31:0] w_instr;

   logic [31:0] pc_a, pc4_a, ins_a, pc_b, pc4_b, ins_b;
   logic        val_a, val_b;
   logic [15:0] stall_a, flush_a;
   logic [1:0]  stall_b, flush_b;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int unsigned m_stall, m_flush;

   always #5 clk = ~clk;

   // instruction memory stand-in: content is a function of the fetch address
   assign w_instr = pc_a ^ InstrKey;

   fetch_stage #(.PC_RESET(PcReset), .CNT_WIDTH(16)) u_dut_a (
      .clk(clk), .reset(reset), .PC_write_i(pc_wr), .IFID_write_i(ifid_wr),
      .redirect_i(redir), .redirect_pc_i(redir_pc), .instr_i(w_instr),
      .pc_o(pc_a), .pc_plus4_IFID_o(pc4_a), .instr_IFID_o(ins_a), .valid_IFID_o(val_a),
      .stall_count_o(stall_a), .flush_count_o(flush_a)
   );

   fetch_stage #(.PC_RESET(PcReset), .CNT_WIDTH(2)) u_dut_b (
      .clk(clk), .reset(reset), .PC_write_i(pc_wr), .IFID_write_i(ifid_wr),
      .redirect_i(redir), .redirect_pc_i(redir_pc), .instr_i(pc_b ^ InstrKey),
      .pc_o(pc_b), .pc_plus4_IFID_o(pc4_b), .instr_IFID_o(ins_b), .valid_IFID_o(val_b),
      .stall_count_o(stall_b), .flush_count_o(flush_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
      int unsigned max_v;
      max_v = (1 << w) - 1;
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic model_edge(input logic rn, input logic pw, input logic iw, input logic rd,
                             input logic [31:0] tgt);
      logic taken;
      logic [31:0] old_pc;
      if (!rn) begin
         m_pc = PcReset; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
         return;
      end
      taken  = rd && pw && iw;
      old_pc = m_pc;
      if (taken) m_pc = tgt & 32'hFFFF_FFFC;
      else if (pw) m_pc = old_pc + 32'd4;
      if (taken) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (iw) begin
         m_instr = old_pc ^ InstrKey; m_pc4 = old_pc + 32'd4; m_valid = 1;
      end
      if (!iw) m_stall++;
      if (taken) m_flush++;
   endtask

   task automatic check_all();
      check_eq("pc_a", pc_a, m_pc);
      check_eq("pc4_a", pc4_a, m_pc4);
      check_eq("instr_a", ins_a, m_instr);
      check_eq("valid_a", {31'h0, val_a}, {31'h0, m_valid});
      check_eq("stall16", {16'h0, stall_a}, sat(m_stall, 16));
      check_eq("flush16", {16'h0, flush_a}, sat(m_flush, 16));
      check_eq("pc_b", pc_b, m_pc);
      check_eq("instr_b", ins_b, m_instr);
      check_eq("stall2", {30'h0, stall_b}, sat(m_stall, 2));
      check_eq("flush2", {30'h0, flush_b}, sat(m_flush, 2));
   endtask

   task automatic cycle(input logic rn, input logic pw, input logic iw, input logic rd,
                        input logic [31:0] tgt);
      reset = rn; pc_wr = pw; ifid_wr = iw; redir = rd; redir_pc = tgt;
      @(posedge clk);
      model_edge(rn, pw, iw, rd, tgt);
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] stall_seq [5];
      logic [31:0] t;
      logic        rn, pw, iw, rd;
      stall_seq = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
      reset = 0; pc_wr = 1; ifid_wr = 1; redir = 0; redir_pc = 0;
      #1;

      // reset, free-run
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      check_eq("rst_pc", pc_a, 32'h0040_0000);
      cycle(1, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      check_eq("run_pc", pc_a, 32'h0040_0008);
      check_eq("run_pc4", pc4_a, 32'h0040_0008);

      // load-use stall for two cycles, then resume
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check_eq("stall_pc", pc_a, 32'h0040_0008);
      check_eq("stall_cnt", {16'h0, stall_a}, 32'd2);
      cycle(1, 1, 1, 0, 0);
      check_eq("resume_pc", pc_a, 32'h0040_000C);

      // redirect with misaligned target
      cycle(1, 1, 1, 1, 32'h0040_0103);
      check_eq("redir_pc", pc_a, 32'h0040_0100);
      check_eq("redir_valid", {31'h0, val_a}, 32'd0);
      cycle(1, 1, 1, 0, 0);
      check_eq("target_instr", ins_a, 32'hA5E5_A4A5);
      check_eq("flush_cnt", {16'h0, flush_a}, 32'd1);

      // redirect during stall ignored, then taken
      cycle(0, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      cycle(1, 0, 0, 1, 32'h0000_1000);
      check_eq("ign_flush", {16'h0, flush_a}, 32'd0);
      cycle(1, 1, 1, 1, 32'h0000_1000);
      check_eq("take_pc", pc_a, 32'h0000_1000);
      check_eq("take_flush", {16'h0, flush_a}, 32'd1);

      // 2-bit stall counter saturation
      cycle(0, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, 0, 0, 0);
         check_eq("sat2", {30'h0, stall_b}, stall_seq[i]);
      end

      // PC wrap, then reset
      cycle(1, 1, 1, 1, 32'hFFFF_FFFC);
      check_eq("wrap_top", pc_a, 32'hFFFF_FFFC);
      cycle(1, 1, 1, 0, 0);
      check_eq("wrap_zero", pc_a, 32'h0000_0000);
      cycle(0, 1, 1, 1, 32'h1234_5678);
      check_eq("final_rst_pc", pc_a, PcReset);
      check_eq("final_rst_valid", {31'h0, val_a}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rn = ($urandom_range(0, 49) != 0);
         case ($urandom_range(0, 5))
            0: begin pw = 0; iw = 0; end
            1: begin pw = 1; iw = 0; end
            2: begin pw = 0; iw = 1; end
            default: begin pw = 1; iw = 1; end
         endcase
         rd = ($urandom_range(0, 5) == 0);
         t  = $urandom;
         cycle(rn, pw, iw, rd, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
